alu_exec_unit: RTL and testbench

Execution stage fed directly by the ALU control decoder. It takes the decoder's 3-bit operation select plus two operands and produces a registered result.
- AND, OR, SUB, ADD, SLT and NOP complete in a single cycle.
- MUL (shift-add) and DIV (restoring, unsigned) are iterative and take DATA_W cycles.
- A valid/ready handshake on each side lets the datapath stall while a multi-cycle op is in flight.

---
 rtl/alu_exec_unit.sv | 175 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execution stage behind the ALU control decoder: single-cycle logic/arith ops plus
// optional iterative MUL/DIV (enabled by defining ALU_MULDIV_EN), with valid/ready on both sides.
module alu_exec_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              div0
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;
    localparam logic [2:0] OP_ADD = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_DONE} state_t;
`endif

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] result_next;
    logic              div0_next;
    logic              load_result;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_SUB:  alu_res = a - b;
            OP_ADD:  alu_res = a + b;
            OP_SLT:  alu_res = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // opx holds multiplicand or divisor, opy multiplier or quotient, acc the product or remainder
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] opx;
    logic [DATA_W-1:0] opy;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_diff;
    logic              div_ge;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;

    always_comb begin
        mul_sum   = acc + (opy[0] ? opx : '0);
        div_shift = {acc, opy[DATA_W-1]};
        div_diff  = div_shift - {1'b0, opx};
        div_ge    = (div_shift >= {1'b0, opx});
        rem_next  = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
        quo_next  = {opy[DATA_W-2:0], div_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            opx <= '0;
            opy <= '0;
            cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    acc <= '0;
                    opx <= (op == OP_DIV) ? b : a;
                    opy <= (op == OP_DIV) ? a : b;
                    cnt <= CNT_W'(DATA_W);
                end
                S_MUL: begin
                    acc <= mul_sum;
                    opx <= opx << 1;
                    opy <= opy >> 1;
                    cnt <= cnt - CNT_W'(1);
                end
                S_DIV: begin
                    acc <= rem_next;
                    opy <= quo_next;
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_result = 1'b0;
        result_next = alu_res;
        div0_next   = 1'b0;
        case (state)
            S_IDLE: if (in_valid) begin
`ifdef ALU_MULDIV_EN
                if (op == OP_MUL) begin
                    state_next = S_MUL;
                end else if (op == OP_DIV && b != '0) begin
                    state_next = S_DIV;
                end else begin
                    load_result = 1'b1;
                    result_next = (op == OP_DIV) ? '1 : alu_res;
                    div0_next   = (op == OP_DIV);
                    state_next  = S_DONE;
                end
`else
                load_result = 1'b1;
                div0_next   = (op == OP_MUL) || (op == OP_DIV);
                state_next  = S_DONE;
`endif
            end
`ifdef ALU_MULDIV_EN
            S_MUL: if (cnt == CNT_W'(1)) begin
                load_result = 1'b1;
                result_next = mul_sum;
                state_next  = S_DONE;
            end
            S_DIV: if (cnt == CNT_W'(1)) begin
                load_result = 1'b1;
                result_next = quo_next;
                state_next  = S_DONE;
            end
`endif
            S_DONE: if (out_ready) begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // zero and div0 only move together with a newly registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            zero   <= 1'b0;
            div0   <= 1'b0;
        end else if (load_result) begin
            result <= result_next;
            zero   <= (result_next == '0);
            div0   <= div0_next;
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases from the test plan plus randomized
// operations compared against a plain-arithmetic reference model (honours ALU_MULDIV_EN).
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         div0;

    int compared   = 0;
    int mismatched = 0;

    alu_exec_unit #(.DATA_W(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: lat is the edge, counted from the accept edge, whose update raises out_valid.
    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic d0, output int lat);
        logic [2*W-1:0] prod;
        r = '0; d0 = 1'b0; lat = 0;
        case (o)
            3'd0: r = '0;
            3'd1: r = x & y;
            3'd2: r = x | y;
            3'd3: r = x - y;
            3'd6: r = x + y;
            3'd7: r = ($signed(x) < $signed(y)) ? 1 : 0;
`ifdef ALU_MULDIV_EN
            3'd4: begin prod = x * y; r = prod[W-1:0]; lat = W; end
            3'd5: if (y == 0) begin r = '1; d0 = 1'b1; end
                  else begin r = x / y; lat = W; end
`else
            3'd4: d0 = 1'b1;
            3'd5: d0 = 1'b1;
`endif
            default: r = '0;
        endcase
    endtask

    task automatic apply_stimulus(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input int hold);
        logic [W-1:0] exp_r;
        logic         exp_d0;
        int           exp_lat;
        int           n;
        model(o, x, y, exp_r, exp_d0, exp_lat);
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        check_output("ready_before_accept", in_ready, 1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        check_output("ready_after_accept", in_ready, 0);
        n = 0;
        while (!out_valid && n < 100) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check_output("latency", n, exp_lat);
        check_output("result", result, exp_r);
        check_output("zero", zero, (exp_r == 0));
        check_output("div0", div0, exp_d0);
        check_output("ready_in_done", in_ready, 0);
        repeat (hold) begin
            @(posedge clk); #1;
            check_output("hold_result", result, exp_r);
            check_output("hold_valid", out_valid, 1);
            check_output("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_output("consume_valid", out_valid, 0);
        check_output("consume_ready", in_ready, 1);
        check_output("idle_result_kept", result, exp_r);
    endtask

    task automatic reset_check(input string tag);
        #3 rst_n = 1'b0;
        #1;
        check_output({tag, "_in_ready"}, in_ready, 1);
        check_output({tag, "_out_valid"}, out_valid, 0);
        check_output({tag, "_result"}, result, 0);
        check_output({tag, "_zero"}, zero, 0);
        check_output({tag, "_div0"}, div0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        #12;
        check_output("reset_in_ready", in_ready, 1);
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_result", result, 0);
        check_output("reset_zero", zero, 0);
        check_output("reset_div0", div0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        apply_stimulus(3'd6, 32'h7FFF_FFFF, 32'h1, 0);
        apply_stimulus(3'd3, 32'd5, 32'd5, 0);
        apply_stimulus(3'd7, 32'hFFFF_FFFF, 32'h1, 0);
        apply_stimulus(3'd7, 32'h1, 32'hFFFF_FFFF, 0);
        apply_stimulus(3'd1, 32'hF0F0_1234, 32'h0FF0_FFFF, 1);
        apply_stimulus(3'd2, 32'hF0F0_0000, 32'h0000_1234, 0);
        apply_stimulus(3'd0, 32'hDEAD_BEEF, 32'h1234_5678, 0);
        apply_stimulus(3'd4, 32'h0001_2345, 32'h0001_0000, 0);
        apply_stimulus(3'd5, 32'd100, 32'd7, 0);
        apply_stimulus(3'd5, 32'd9, 32'd0, 0);
        apply_stimulus(3'd6, 32'h8000_0000, 32'h8000_0000, 10);

        // leave a nonzero result behind, then reset while it is presented
        op = 3'd6; a = 32'h55; b = 32'h1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset_check("rst_done");
        // reset during a (possibly iterative) division
        op = 3'd5; a = 32'hFFFF_0000; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        reset_check("rst_busy");

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            apply_stimulus(ro, ra, rb, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
